// File: rtl/mem_access_pkg.sv
// Shared parameters for the memory-access stage: default widths, default
// timeout and the FSM state encoding.
package mem_access_pkg;

  localparam int unsigned DEFAULT_ADDR    = 32;
  localparam int unsigned DEFAULT_W_OPR   = 32;
  localparam int unsigned DEFAULT_TIMEOUT = 255;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mem_req_reg.sv
// Capture register for one load/store request (address, write flag, data, tag).
module mem_req_reg #(
  parameter int unsigned ADDR  = 32,
  parameter int unsigned W_OPR = 32,
  parameter int unsigned W_RD  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [ADDR-1:0]  addr,
  input  logic             write,
  input  logic [W_OPR-1:0] data,
  input  logic [W_RD-1:0]  rd,
  output logic [ADDR-1:0]  q_addr,
  output logic             q_write,
  output logic [W_OPR-1:0] q_data,
  output logic [W_RD-1:0]  q_rd
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_addr  <= '0;
      q_write <= 1'b0;
      q_data  <= '0;
      q_rd    <= '0;
    end else if (en) begin
      q_addr  <= addr;
      q_write <= write;
      q_data  <= data;
      q_rd    <= rd;
    end
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: one outstanding load/store on a req/ack memory port.
// Define MEM_TIMEOUT_EN to add an ack timeout with the err_o pulse output.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR    = DEFAULT_ADDR,
  parameter int unsigned W_OPR   = DEFAULT_W_OPR,
`ifdef MEM_TIMEOUT_EN
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
`endif
  parameter int unsigned W_RD    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [ADDR-1:0]  addr_i,
  input  logic             write_i,
  input  logic [W_OPR-1:0] data_i,
  input  logic [W_RD-1:0]  rd_i,
  output logic             stall_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [ADDR-1:0]  mem_addr_o,
  output logic [W_OPR-1:0] mem_wdata_o,
  input  logic             mem_ack_i,
  input  logic [W_OPR-1:0] mem_rdata_i,
`ifdef MEM_TIMEOUT_EN
  output logic             err_o,
`endif
  output logic             wb_valid_o,
  output logic [W_OPR-1:0] wb_data_o,
  output logic [W_RD-1:0]  wb_rd_o
);

  state_t state, state_next;
  logic busy, accept, tmo;
  logic             q_write;
  logic [W_RD-1:0]  q_rd;

  assign busy   = (state == S_BUSY);
  assign accept = (state == S_IDLE) && valid_i;

  mem_req_reg #(
    .ADDR (ADDR),
    .W_OPR(W_OPR),
    .W_RD (W_RD)
  ) u_req (
    .clk    (clk),
    .rst    (rst),
    .en     (accept),
    .addr   (addr_i),
    .write  (write_i),
    .data   (data_i),
    .rd     (rd_i),
    .q_addr (mem_addr_o),
    .q_write(q_write),
    .q_data (mem_wdata_o),
    .q_rd   (q_rd)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt, cnt_inc;

  assign cnt_inc = cnt + 1'b1;
  // Ack takes priority: a timeout only fires in a BUSY cycle without ack.
  assign tmo = busy && !mem_ack_i && (cnt_inc == CW'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      err_o <= 1'b0;
    end else begin
      err_o <= tmo;
      if (accept)
        cnt <= '0;
      else if (busy && !mem_ack_i)
        cnt <= cnt_inc;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (valid_i) state_next = S_BUSY;
      S_BUSY: if (mem_ack_i || tmo) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_o <= 1'b0;
      wb_data_o  <= '0;
      wb_rd_o    <= '0;
    end else begin
      wb_valid_o <= busy && mem_ack_i && !q_write;
      if (busy && mem_ack_i && !q_write) begin
        wb_data_o <= mem_rdata_i;
        wb_rd_o   <= q_rd;
      end
    end
  end

  assign stall_o   = busy;
  assign mem_req_o = busy;
  assign mem_we_o  = busy && q_write;

endmodule
